// File: rtl/seven_segment_reader.sv
// seven_segment_reader
//
// Snoops a time-multiplexed, active-low seven-segment display bus and
// recovers one BCD value per digit. A digit is captured once its enable
// and segment pattern have been seen unchanged for STABLE_CYCLES
// consecutive samples. Intervals with zero or several enables low are
// treated as inter-digit gaps.
//
// Parameters:
//   NUM_DIGITS    number of multiplexed digits (1..8)
//   STABLE_CYCLES identical samples needed before a capture (1..15)
//
// Ports:
//   clock        in   system clock, rising edge
//   reset_L      in   asynchronous active-low reset
//   segment      in   [6:0] active-low segments, bit 6 = g ... bit 0 = a
//   digit_en_L   in   [NUM_DIGITS-1:0] active-low digit enables
//   bcd_out      out  [4*NUM_DIGITS-1:0] recovered values, digit i at [4i+3:4i]
//   blank        out  [NUM_DIGITS-1:0] digit last captured as all-off
//   error        out  [NUM_DIGITS-1:0] digit last captured as undecodable
//   update       out  one-cycle pulse following each capture
//   frame_valid  out  one-cycle pulse when every digit has been captured
//
// Build option:
//   SEVSEG_HEX_EN  when defined, the patterns A b C d E F decode to 10..15
//                  instead of being flagged as errors.

module seven_segment_reader #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic                      clock,
  input  logic                      reset_L,
  input  logic [6:0]                segment,
  input  logic [NUM_DIGITS-1:0]     digit_en_L,
  output logic [4*NUM_DIGITS-1:0]   bcd_out,
  output logic [NUM_DIGITS-1:0]     blank,
  output logic [NUM_DIGITS-1:0]     error,
  output logic                      update,
  output logic                      frame_valid
);

  localparam int unsigned SampleW  = NUM_DIGITS + 7;
  localparam logic [3:0]  StableN  = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCaptured
  } state_e;

  // Decoded pattern packed as {blank, error, value}.
  function automatic logic [5:0] f_decode(input logic [6:0] seg);
    logic [5:0] res;
    case (seg)
      7'h40:   res = {2'b00, 4'd0};
      7'h79:   res = {2'b00, 4'd1};
      7'h24:   res = {2'b00, 4'd2};
      7'h30:   res = {2'b00, 4'd3};
      7'h19:   res = {2'b00, 4'd4};
      7'h12:   res = {2'b00, 4'd5};
      7'h02:   res = {2'b00, 4'd6};
      7'h78:   res = {2'b00, 4'd7};
      7'h00:   res = {2'b00, 4'd8};
      7'h18:   res = {2'b00, 4'd9};
`ifdef SEVSEG_HEX_EN
      7'h08:   res = {2'b00, 4'd10};
      7'h03:   res = {2'b00, 4'd11};
      7'h46:   res = {2'b00, 4'd12};
      7'h21:   res = {2'b00, 4'd13};
      7'h06:   res = {2'b00, 4'd14};
      7'h0E:   res = {2'b00, 4'd15};
`endif
      7'h7F:   res = {2'b10, 4'hF};
      default: res = {2'b01, 4'hF};
    endcase
    return res;
  endfunction

  // Registered bus sample and the sample the FSM looked at one cycle earlier.
  logic [SampleW-1:0]      r_sample;
  logic [SampleW-1:0]      r_prev;

  state_e                  r_state;
  state_e                  w_state_d;
  logic [3:0]              r_count;
  logic [3:0]              w_count_d;
  logic                    w_capture;

  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic [4*NUM_DIGITS-1:0] w_bcd_d;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [NUM_DIGITS-1:0]   w_blank_d;
  logic [NUM_DIGITS-1:0]   r_error;
  logic [NUM_DIGITS-1:0]   w_error_d;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [NUM_DIGITS-1:0]   w_seen_d;
  logic [NUM_DIGITS-1:0]   w_seen_set;
  logic                    r_update;
  logic                    r_frame;
  logic                    w_frame;

  logic [NUM_DIGITS-1:0]   w_sel;
  logic [3:0]              w_ones;
  logic                    w_onehot;
  logic                    w_changed;
  logic [5:0]              w_dec;

  // Enables are active-low, so the selected digit is the single high bit of w_sel.
  assign w_sel     = ~r_sample[SampleW-1:7];
  assign w_changed = (r_sample != r_prev);
  assign w_dec     = f_decode(r_sample[6:0]);

  always_comb begin
    w_ones = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      w_ones = w_ones + {3'b000, w_sel[i]};
    end
    w_onehot = (w_ones == 4'd1);
  end

  // Dwell tracking: the counter holds the length of the current run of
  // identical one-hot samples; capture fires when it reaches StableN.
  always_comb begin
    w_state_d = r_state;
    w_count_d = r_count;
    w_capture = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_onehot) begin
          w_state_d = StSettle;
          w_count_d = 4'd1;
        end else begin
          w_count_d = '0;
        end
      end
      StSettle: begin
        if (!w_onehot) begin
          w_state_d = StIdle;
          w_count_d = '0;
        end else if (w_changed) begin
          w_count_d = 4'd1;
        end else begin
          w_count_d = r_count + 4'd1;
        end
      end
      StCaptured: begin
        if (w_changed) begin
          if (w_onehot) begin
            w_state_d = StSettle;
            w_count_d = 4'd1;
          end else begin
            w_state_d = StIdle;
            w_count_d = '0;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_count_d = '0;
      end
    endcase

    // Shared capture check so STABLE_CYCLES = 1 captures on the first valid sample.
    if (w_state_d == StSettle && w_count_d >= StableN) begin
      w_capture = 1'b1;
      w_state_d = StCaptured;
    end
  end

  always_comb begin
    w_bcd_d    = r_bcd;
    w_blank_d  = r_blank;
    w_error_d  = r_error;
    w_seen_d   = r_seen;
    w_seen_set = r_seen | w_sel;
    w_frame    = 1'b0;

    if (w_capture) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (w_sel[i]) begin
          w_bcd_d[4*i +: 4] = w_dec[3:0];
          w_blank_d[i]      = w_dec[5];
          w_error_d[i]      = w_dec[4];
        end
      end
      // Completing the mask reports the frame and starts a new one.
      w_frame  = &w_seen_set;
      w_seen_d = w_frame ? '0 : w_seen_set;
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_sample <= '1;
      r_prev   <= '1;
      r_state  <= StIdle;
      r_count  <= '0;
      r_bcd    <= '1;
      r_blank  <= '1;
      r_error  <= '0;
      r_seen   <= '0;
      r_update <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      r_sample <= {digit_en_L, segment};
      r_prev   <= r_sample;
      r_state  <= w_state_d;
      r_count  <= w_count_d;
      r_bcd    <= w_bcd_d;
      r_blank  <= w_blank_d;
      r_error  <= w_error_d;
      r_seen   <= w_seen_d;
      r_update <= w_capture;
      r_frame  <= w_frame;
    end
  end

  assign bcd_out     = r_bcd;
  assign blank       = r_blank;
  assign error       = r_error;
  assign update      = r_update;
  assign frame_valid = r_frame;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader (NUM_DIGITS = 4, STABLE_CYCLES = 3).
// Directed dwell table plus random dwells, every cycle checked against a
// run-length reference model of the display bus.

module tb_seven_segment_reader;

  localparam int ND = 4;
  localparam int SC = 3;

`ifdef SEVSEG_HEX_EN
  localparam int NVAL = 16;
  localparam logic [15:0] B13 = 16'h3A60;
  localparam logic [15:0] B14 = 16'h3A6F;
  localparam logic [15:0] B15 = 16'h4A6F;
  localparam logic [3:0]  E13 = 4'b0000;
`else
  localparam int NVAL = 10;
  localparam logic [15:0] B13 = 16'h3F60;
  localparam logic [15:0] B14 = 16'h3F6F;
  localparam logic [15:0] B15 = 16'h4F6F;
  localparam logic [3:0]  E13 = 4'b0100;
`endif

  logic        clock = 1'b0;
  logic        reset_L = 1'b0;
  logic [6:0]  segment = 7'h7F;
  logic [3:0]  digit_en_L = 4'hF;
  logic [15:0] bcd_out;
  logic [3:0]  blank;
  logic [3:0]  error;
  logic        update;
  logic        frame_valid;

  int total = 0;
  int bad = 0;

  seven_segment_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .segment     (segment),
    .digit_en_L  (digit_en_L),
    .bcd_out     (bcd_out),
    .blank       (blank),
    .error       (error),
    .update      (update),
    .frame_valid (frame_valid)
  );

  always #5 clock = ~clock;

  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: input waiting to be seen, last seen input, run length.
  logic [10:0] m_pend;
  logic [10:0] m_last;
  int          m_run;
  logic [15:0] m_bcd;
  logic [3:0]  m_blank;
  logic [3:0]  m_err;
  logic [3:0]  m_seen;
  logic        m_upd;
  logic        m_fv;
  int          n_upd;
  int          n_fv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = '1;
    m_last  = '1;
    m_run   = 0;
    m_bcd   = 16'hFFFF;
    m_blank = 4'hF;
    m_err   = 4'h0;
    m_seen  = 4'h0;
    m_upd   = 1'b0;
    m_fv    = 1'b0;
  endtask

  // One clock edge: the input driven before the previous edge is judged now.
  task automatic model_edge(input logic [10:0] cur);
    logic [3:0] sel;
    logic [3:0] v;
    logic       is_b;
    logic       is_e;
    int         d;
    m_upd = 1'b0;
    m_fv  = 1'b0;
    sel   = ~m_pend[10:7];
    if ($countones(sel) != 1)                 m_run = 0;
    else if (m_run > 0 && m_pend == m_last)   m_run = m_run + 1;
    else                                      m_run = 1;
    m_last = m_pend;
    if (m_run == SC) begin
      d = 0;
      for (int k = 0; k < ND; k++) if (sel[k]) d = k;
      v    = 4'hF;
      is_b = (m_pend[6:0] == 7'h7F);
      is_e = !is_b;
      for (int k = 0; k < NVAL; k++) begin
        if (pat[k] == m_pend[6:0]) begin
          v    = k[3:0];
          is_e = 1'b0;
        end
      end
      m_bcd[4*d +: 4] = v;
      m_blank[d]      = is_b;
      m_err[d]        = is_e;
      m_upd           = 1'b1;
      m_seen[d]       = 1'b1;
      if (&m_seen) begin
        m_fv   = 1'b1;
        m_seen = 4'h0;
      end
    end
    m_pend = cur;
  endtask

  task automatic step(input logic [3:0] en, input logic [6:0] seg);
    digit_en_L = en;
    segment    = seg;
    @(posedge clock);
    #1;
    model_edge({en, seg});
    check("step", {6'b0, bcd_out, blank, error, update, frame_valid},
          {6'b0, m_bcd, m_blank, m_err, m_upd, m_fv});
    n_upd += int'(update);
    n_fv  += int'(frame_valid);
  endtask

  typedef struct {
    logic [3:0]  en;
    logic [6:0]  seg;
    int          cyc;
    logic [15:0] bcd;
    logic [3:0]  blk;
    logic [3:0]  err;
    int          upd;
    int          fv;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int first_upd;
    logic [3:0] en;
    logic [6:0] seg;
    int r;
    int len;

    tbl[0]  = '{4'b1110, 7'h24, 5, 16'hFFF2, 4'b1110, 4'b0000, 1, 0};
    tbl[1]  = '{4'b1110, 7'h40, 4, 16'hFFF0, 4'b1110, 4'b0000, 1, 0};
    tbl[2]  = '{4'b1101, 7'h79, 4, 16'hFF10, 4'b1100, 4'b0000, 1, 0};
    tbl[3]  = '{4'b1011, 7'h24, 4, 16'hF210, 4'b1000, 4'b0000, 1, 0};
    tbl[4]  = '{4'b0111, 7'h30, 4, 16'h3210, 4'b0000, 4'b0000, 1, 1};
    tbl[5]  = '{4'b1110, 7'h40, 4, 16'h3210, 4'b0000, 4'b0000, 1, 0};
    tbl[6]  = '{4'b1101, 7'h79, 4, 16'h3210, 4'b0000, 4'b0000, 1, 0};
    tbl[7]  = '{4'b1011, 7'h24, 4, 16'h3210, 4'b0000, 4'b0000, 1, 0};
    tbl[8]  = '{4'b0111, 7'h30, 4, 16'h3210, 4'b0000, 4'b0000, 1, 1};
    tbl[9]  = '{4'b1101, 7'h12, 2, 16'h3210, 4'b0000, 4'b0000, 0, 0};
    tbl[10] = '{4'b1101, 7'h02, 3, 16'h3210, 4'b0000, 4'b0000, 0, 0};
    tbl[11] = '{4'b1111, 7'h7F, 2, 16'h3260, 4'b0000, 4'b0000, 1, 0};
    tbl[12] = '{4'b1100, 7'h00, 6, 16'h3260, 4'b0000, 4'b0000, 0, 0};
    tbl[13] = '{4'b1011, 7'h08, 4, B13,      4'b0000, E13,     1, 0};
    tbl[14] = '{4'b1110, 7'h7F, 4, B14,      4'b0001, E13,     1, 0};
    tbl[15] = '{4'b0111, 7'h19, 4, B15,      4'b0001, E13,     1, 1};

    // Reset state with the bus idle.
    model_reset();
    n_upd = 0;
    n_fv  = 0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_bcd", {16'b0, bcd_out}, 32'h0000FFFF);
    check("reset_flags", {26'b0, blank, error, update, frame_valid}, {26'b0, 4'hF, 4'h0, 2'b00});
    #2 reset_L = 1'b1;
    repeat (3) step(4'hF, 7'h7F);
    check("idle_no_update", n_upd, 0);

    // Directed dwells.
    for (int i = 0; i < 16; i++) begin
      n_upd = 0;
      n_fv  = 0;
      for (int c = 0; c < tbl[i].cyc; c++) step(tbl[i].en, tbl[i].seg);
      check($sformatf("vec%0d_bcd", i), {16'b0, bcd_out}, {16'b0, tbl[i].bcd});
      check($sformatf("vec%0d_blank", i), {28'b0, blank}, {28'b0, tbl[i].blk});
      check($sformatf("vec%0d_error", i), {28'b0, error}, {28'b0, tbl[i].err});
      check($sformatf("vec%0d_updates", i), n_upd, tbl[i].upd);
      check($sformatf("vec%0d_frames", i), n_fv, tbl[i].fv);
    end

    // Asynchronous reset in the middle of a dwell.
    step(4'b0111, 7'h78);
    step(4'b0111, 7'h78);
    #2 reset_L = 1'b0;
    #1;
    check("async_reset_bcd", {16'b0, bcd_out}, 32'h0000FFFF);
    check("async_reset_flags", {26'b0, blank, error, update, frame_valid},
          {26'b0, 4'hF, 4'h0, 2'b00});
    model_reset();
    repeat (2) @(posedge clock);
    #2 reset_L = 1'b1;

    // After release a full dwell is needed: update only after the 4th edge.
    first_upd = 0;
    n_upd = 0;
    for (int c = 1; c <= 6; c++) begin
      step(4'b0111, 7'h78);
      if (update && first_upd == 0) first_upd = c;
    end
    check("post_reset_latency", first_upd, 4);
    check("post_reset_updates", n_upd, 1);
    check("post_reset_nibble3", {28'b0, bcd_out[15:12]}, 32'd7);

    // Random dwells, including gaps, overlaps, glitches and bad patterns.
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 4) == 0) en = 4'($urandom);
      else                           en = ~(4'b0001 << $urandom_range(0, 3));
      r = $urandom_range(0, 19);
      if (r < 16)       seg = pat[r];
      else if (r == 16) seg = 7'h7F;
      else              seg = 7'($urandom);
      len = $urandom_range(1, 6);
      for (int c = 0; c < len; c++) step(en, seg);
    end
    repeat (SC + 1) step(4'hF, 7'h7F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
